// File: rtl/slice_add_seq.sv
// -----------------------------------------------------------------------------
// slice_add_seq
//
// Performs one wide addition of W*N bits by time-multiplexing a single external
// W-bit adder slice over N consecutive cycles, least-significant slice first.
// The carry between slices travels through a register only. The adder itself
// is outside this block, so its critical path never spans more than one slice.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   start_valid/ready   requester handshake; ready only while IDLE
//   a_in, b_in, ci_in   operands and carry-in, latched when the start is accepted
//   add_a/add_b/add_ci  slice operands to the external adder (0 unless RUN)
//   add_s/add_co        combinational slice result returned by the adder
//   res, co             assembled sum and final carry-out
//   res_valid/ready     result handshake; valid only in DONE
//   busy                high while an operation is in flight (RUN or DONE)
// -----------------------------------------------------------------------------
module slice_add_seq #(
  parameter int W = 5,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [W*N-1:0] a_in,
  input  logic [W*N-1:0] b_in,
  input  logic           ci_in,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  output logic           add_ci,
  input  logic [W-1:0]   add_s,
  input  logic           add_co,
  output logic [W*N-1:0] res,
  output logic           co,
  output logic           res_valid,
  input  logic           res_ready,
  output logic           busy
);

  localparam int WN = W * N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            carry_q;
  logic [WN-1:0]   a_q, b_q;
  logic [WN-1:0]   res_q;
  logic            co_q;
  logic            last_slice;

  assign last_slice = (cnt_q == CW'(N - 1));

  // Next-state logic.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_valid) state_d = RUN;
      RUN:  if (last_slice)  state_d = DONE;
      DONE: if (res_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state. The adder inputs are forced to 0
  // outside RUN so the shared slice sees a quiet bus when not in use.
  always_comb begin
    start_ready = (state_q == IDLE);
    res_valid   = (state_q == DONE);
    busy        = (state_q != IDLE);
    add_a       = '0;
    add_b       = '0;
    add_ci      = 1'b0;
    if (state_q == RUN) begin
      add_a  = a_q[W*int'(cnt_q) +: W];
      add_b  = b_q[W*int'(cnt_q) +: W];
      add_ci = carry_q;
    end
  end

  assign res = res_q;
  assign co  = co_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement or process order.
      state_q <= state_d;
    end
  end

  // Datapath registers. Operands are reset as well so that an aborted
  // operation leaves nothing behind for the next one to observe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q     <= a_in;
            b_q     <= b_in;
            carry_q <= ci_in;
            cnt_q   <= '0;
            res_q   <= '0;
          end
        end
        RUN: begin
          // The slice result is sampled in the same cycle its operands are
          // driven; the carry is only ever passed on through carry_q.
          res_q[W*int'(cnt_q) +: W] <= add_s;
          carry_q                   <= add_co;
          cnt_q                     <= cnt_q + 1'b1;
          if (last_slice) co_q <= add_co;
        end
        default: ; // DONE holds res/co stable until the consumer takes them
      endcase
    end
  end

endmodule

// File: doc/slice_add_seq.md
Name: slice_add_seq

Overview:
- Sequencer that performs one wide addition (W*N bits) by driving a single external W-bit adder slice (sum/carry datapath, 5-bit by default) for N consecutive cycles, least-significant slice first.
- Chains the carry between slices through a register.
- Sits between a requester (valid/ready) and the shared adder slice, and returns the assembled result with a valid/ready handshake.

Parameters:
W, 5, adder slice width in bits
N, 4, number of slices per operation (operand width = W*N)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
start_valid  input  1  requester presents operands
start_ready  output  1  sequencer can accept an operation (high only in IDLE)
a_in  input  W*N  operand A
b_in  input  W*N  operand B
ci_in  input  1  carry-in for slice 0
add_a  output  W  slice operand A to adder
add_b  output  W  slice operand B to adder
add_ci  output  1  slice carry-in to adder
add_s  input  W  slice sum from adder (combinational return)
add_co  input  1  slice carry-out from adder
res  output  W*N  assembled sum
co  output  1  final carry-out
res_valid  output  1  res/co valid
res_ready  input  1  consumer accepts result
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. rst_n low forces the following immediately, regardless of clock:
  - state=IDLE.
  - start_ready=1; res_valid=0; busy=0.
  - res=0; co=0.
  - add_a=0; add_b=0; add_ci=0.
  - slice counter=0; carry register=0; operand registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1; adder outputs driven 0.
  - On an edge with start_valid=1: latch a_in, b_in, ci_in; carry register<=ci_in; counter<=0; clear res to 0; go to RUN.
- RUN (cycle k = 0..N-1):
  - add_a=A[k*W +: W]; add_b=B[k*W +: W]; add_ci=carry register.
  - On each edge: res[k*W +: W]<=add_s; carry register<=add_co; counter<=k+1.
  - On the edge ending k=N-1: co<=add_co; go to DONE.
  - start_ready=0. start_valid is ignored, and a_in/b_in changes have no effect.
- DONE:
  - res_valid=1; res and co held stable; adder outputs driven 0.
  - On an edge with res_ready=1: res_valid<=0; go to IDLE.
  - res_ready=0 holds DONE indefinitely with outputs unchanged.
- Latency and throughput:
  - res_valid rises exactly N cycles after the accepting edge (4 with defaults).
  - With res_ready held high, the minimum issue interval is N+2 cycles.
- Simultaneous events:
  - In DONE, res_valid & res_ready together with start_valid: the result is consumed and the start is NOT accepted that cycle (start_ready=0). It is accepted on the next edge from IDLE.
- Arithmetic:
  - res = (A + B + ci_in) mod 2^(W*N); co = bit W*N of the full sum. Wrap-around is silent.
  - Slice carry propagates only via the register, never combinationally between slices.
- Adder contract: add_s/add_co are sampled at the clock edge in the same cycle add_a/add_b/add_ci are driven. The adder must settle within one cycle.
- Reset mid-operation (RUN or DONE): the operation is aborted, nothing is reported, and all outputs return to reset values. The first operation after rst_n rises behaves as from power-up.
- busy = (state != IDLE).

Test Plan:
- Basic add: a_in=0x00005, b_in=0x0000A, ci_in=0, res_ready=1 -> res=0x0000F, co=0, res_valid high exactly 4 cycles after accept, for 1 cycle.
- Full carry chain: a_in=0xFFFFF, b_in=0x00001, ci_in=0 -> add_ci=0,1,1,1 in RUN cycles 0..3; res=0x00000, co=1.
- Carry-in: a_in=0x00001, b_in=0x00002, ci_in=1 -> slice 0 add_ci=1; res=0x00004, co=0.
- Backpressure: a_in=0x0A0A0, b_in=0x05050, ci_in=0, res_ready=0 for 5 cycles after res_valid, start_valid=1 throughout -> res=0x0F0F0 held, start_ready=0, no second accept. After res_ready=1: one cycle later start_ready=1, and the next accept occurs on the following edge.
- Reset mid-op: assert rst_n=0 asynchronously (between edges) during RUN cycle 2 -> res=0, co=0, res_valid=0, busy=0, add_* =0 immediately. After release, a_in=0x00003, b_in=0x00004 -> res=0x00007 at latency 4.
- Back-to-back: res_ready=1 and start_valid=1 with two operand pairs (0x12345+0x00001, 0x7FFFF+0x7FFFF) -> results 0x12346/co=0 then 0xFFFFE/co=0. Accept edges are 6 cycles apart, and a_in changes during RUN do not affect the first result.
